// File: rtl/avmm_rw_slave_mem.sv
// Word-addressed 64-bit Avalon-MM responder memory with byte-enabled writes and a back-door host port.
// Latency: master reads return after READ_LATENCY cycles; host reads after 1 cycle; writes visible next cycle.
// Backpressure: none, every master and host request is accepted in the cycle it is presented.
module avmm_rw_slave_mem #(
    parameter int          DEPTH        = 1024,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter int          READ_LATENCY = 2,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [63:0]   avs_address,
    input  logic [7:0]    avs_byteenable,
    input  logic          avs_read,
    output logic [63:0]   avs_readdata,
    input  logic          avs_write,
    input  logic [63:0]   avs_writedata,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [63:0]   host_wdata,
    output logic [63:0]   host_rdata,
    output logic          err,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count
);

    // Stages between the memory lookup and the output register; at least one
    // so the arrays stay legal when READ_LATENCY is 1 (they are then bypassed).
    localparam int NP = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    logic [63:0]   r_mem [DEPTH];
    logic [NP-1:0] r_pipe_vld;
    logic [63:0]   r_pipe_dat [NP];
    logic [63:0]   r_readdata;
    logic [63:0]   r_host_rdata;
    logic          r_err;
    logic [31:0]   r_rd_count;
    logic [31:0]   r_wr_count;

    logic [63:0]   w_off;
    logic          w_valid;
    logic [AW-1:0] w_idx;
    logic          w_mst_we;
    logic          w_host_we;
    logic [63:0]   w_rd_dat;
    logic          w_last_vld;
    logic [63:0]   w_last_dat;

    // Address decode relative to the window base; anything misaligned or past
    // the last word is rejected and flagged.
    always_comb begin
        w_off      = avs_address - BASE_ADDR;
        w_valid    = (w_off[2:0] == 3'b000) && (w_off[63:3+AW] == '0);
        w_idx      = w_off[3+AW-1:3];
        w_mst_we   = avs_write && w_valid;
        // Host write to the word the master is writing this cycle is dropped.
        w_host_we  = host_we && !(w_mst_we && (host_addr == w_idx));
        // Lookup happens before this cycle's writes land: read-before-write.
        w_rd_dat   = w_valid ? r_mem[w_idx] : 64'h0;
        w_last_vld = (READ_LATENCY == 1) ? avs_read : r_pipe_vld[NP-1];
        w_last_dat = (READ_LATENCY == 1) ? w_rd_dat : r_pipe_dat[NP-1];
    end

    // Memory array: master byte-lane writes plus host word writes; never reset.
    always_ff @(posedge clock) begin
        if (w_mst_we) begin
            for (int b = 0; b < 8; b++) begin
                if (avs_byteenable[b]) r_mem[w_idx][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
        end
        if (w_host_we) r_mem[host_addr] <= host_wdata;
    end

    // Read latency pipeline; reset flushes in-flight results so none surface later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < NP; i++) r_pipe_dat[i] <= 64'h0;
        end else begin
            r_pipe_vld[0] <= avs_read;
            if (avs_read) r_pipe_dat[0] <= w_rd_dat;
            for (int i = 1; i < NP; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    // Output register holds the most recent read result until the next one arrives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)         r_readdata <= 64'h0;
        else if (w_last_vld) r_readdata <= w_last_dat;
    end

    // Host back-door read port, one cycle, sees pre-write contents.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_host_rdata <= 64'h0;
        else         r_host_rdata <= r_mem[host_addr];
    end

    // Sticky error flag plus saturating request counters (valid or not).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_err      <= 1'b0;
            r_rd_count <= 32'h0;
            r_wr_count <= 32'h0;
        end else begin
            if ((avs_read || avs_write) && !w_valid) r_err <= 1'b1;
            if (avs_read  && (r_rd_count != 32'hFFFF_FFFF)) r_rd_count <= r_rd_count + 32'd1;
            if (avs_write && (r_wr_count != 32'hFFFF_FFFF)) r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign avs_readdata = r_readdata;
    assign host_rdata   = r_host_rdata;
    assign err          = r_err;
    assign rd_count     = r_rd_count;
    assign wr_count     = r_wr_count;

endmodule

// File: tb/tb_avmm_rw_slave_mem.sv
// Bench for avmm_rw_slave_mem: directed scenarios plus randomized traffic against an array model.
// Latency: checks master reads at READ_LATENCY cycles and host reads at 1 cycle.
// Backpressure: none in the DUT; stimulus runs every cycle.
module tb_avmm_rw_slave_mem;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int L     = 2;

    logic          clock;
    logic          resetn;
    logic [63:0]   avs_address;
    logic [7:0]    avs_byteenable;
    logic          avs_read;
    logic [63:0]   avs_readdata;
    logic          avs_write;
    logic [63:0]   avs_writedata;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [63:0]   host_wdata;
    logic [63:0]   host_rdata;
    logic          err;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    int total = 0;
    int bad   = 0;

    // Reference memory image, maintained by the bench for every write it issues.
    logic [63:0] ref_mem [DEPTH];

    avmm_rw_slave_mem #(
        .DEPTH        (DEPTH),
        .BASE_ADDR    (64'h0),
        .READ_LATENCY (L)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .avs_address    (avs_address),
        .avs_byteenable (avs_byteenable),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .err            (err),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = 64'h0;
        avs_byteenable = 8'h00;
        avs_writedata  = 64'h0;
        host_we        = 1'b0;
        host_wdata     = 64'h0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic host_write(input int w, input logic [63:0] d);
        host_we    = 1'b1;
        host_addr  = AW'(w);
        host_wdata = d;
        tick();
        host_we    = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (avs_readdata !== 64'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
        total++; if (host_rdata !== 64'h0 && host_rdata !== ref_mem[host_addr]) begin bad++; $display("FAIL reset_host_rdata got=%h", host_rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (rd_count !== 32'h0) begin bad++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
        total++; if (wr_count !== 32'h0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    endtask

    task automatic preload();
        for (int w = 0; w < DEPTH; w++) host_write(w, {$urandom, $urandom});
    endtask

    task automatic test_latency();
        host_write(5, 64'hDEADBEEF_01234567);
        avs_read    = 1'b1;
        avs_address = 64'h28;
        tick();
        idle();
        total++; if (avs_readdata !== 64'h0) begin bad++; $display("FAIL lat_early got=%h exp=0", avs_readdata); end
        tick();
        total++; if (avs_readdata !== 64'hDEADBEEF_01234567) begin bad++; $display("FAIL lat_data got=%h exp=deadbeef01234567", avs_readdata); end
        total++; if (rd_count !== 32'd1) begin bad++; $display("FAIL lat_rd_count got=%0d exp=1", rd_count); end
        tick();
        total++; if (avs_readdata !== 64'hDEADBEEF_01234567) begin bad++; $display("FAIL lat_hold got=%h", avs_readdata); end
    endtask

    task automatic test_byteenable();
        host_write(3, 64'h0);
        avs_write      = 1'b1;
        avs_address    = 64'h18;
        avs_byteenable = 8'b0000_0101;
        avs_writedata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle();
        ref_mem[3] = 64'h0000_0000_00FF_00FF;
        host_addr  = AW'(3);
        tick();
        total++; if (host_rdata !== 64'h0000_0000_00FF_00FF) begin bad++; $display("FAIL be_word3 got=%h exp=00000000_00ff00ff", host_rdata); end
        total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL be_wr_count got=%0d exp=1", wr_count); end
        // byteenable 0 changes nothing but is counted
        avs_write      = 1'b1;
        avs_address    = 64'h18;
        avs_byteenable = 8'h00;
        avs_writedata  = 64'h1234;
        tick();
        idle();
        tick();
        total++; if (host_rdata !== 64'h0000_0000_00FF_00FF) begin bad++; $display("FAIL be_zero_word3 got=%h exp=00000000_00ff00ff", host_rdata); end
        total++; if (wr_count !== 32'd2) begin bad++; $display("FAIL be_zero_wr_count got=%0d exp=2", wr_count); end
    endtask

    task automatic test_rw_collision();
        host_write(7, 64'h11);
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_address    = 64'h38;
        avs_byteenable = 8'hFF;
        avs_writedata  = 64'h22;
        tick();
        idle();
        ref_mem[7]  = 64'h22;
        avs_read    = 1'b1;
        avs_address = 64'h38;
        tick();
        idle();
        total++; if (avs_readdata !== 64'h11) begin bad++; $display("FAIL rw_col_old got=%h exp=11", avs_readdata); end
        tick();
        total++; if (avs_readdata !== 64'h22) begin bad++; $display("FAIL rw_col_new got=%h exp=22", avs_readdata); end
    endtask

    task automatic test_host_collision();
        avs_write      = 1'b1;
        avs_address    = 64'h48;
        avs_byteenable = 8'hFF;
        avs_writedata  = 64'hAA;
        host_we        = 1'b1;
        host_addr      = AW'(9);
        host_wdata     = 64'hBB;
        tick();
        idle();
        ref_mem[9] = 64'hAA;
        tick();
        total++; if (host_rdata !== 64'hAA) begin bad++; $display("FAIL host_col_word9 got=%h exp=aa", host_rdata); end
        // different words in the same cycle are both written
        avs_write      = 1'b1;
        avs_address    = 64'h50;
        avs_byteenable = 8'hFF;
        avs_writedata  = 64'hCC;
        host_we        = 1'b1;
        host_addr      = AW'(11);
        host_wdata     = 64'hDD;
        tick();
        idle();
        ref_mem[10] = 64'hCC;
        ref_mem[11] = 64'hDD;
        host_addr   = AW'(10);
        tick();
        total++; if (host_rdata !== 64'hCC) begin bad++; $display("FAIL host_diff_word10 got=%h exp=cc", host_rdata); end
        host_addr = AW'(11);
        tick();
        total++; if (host_rdata !== 64'hDD) begin bad++; $display("FAIL host_diff_word11 got=%h exp=dd", host_rdata); end
    endtask

    function automatic logic addr_ok(input logic [63:0] a);
        return (a % 64'd8 == 64'd0) && (a / 64'd8 < 64'(DEPTH));
    endfunction

    function automatic logic [63:0] rand_addr();
        int k;
        int w;
        k = $urandom_range(0, 9);
        w = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH-1);
        if (k == 0) return 64'(w) * 64'd8 + 64'($urandom_range(1, 7));
        if (k == 1) return (64'(DEPTH) + 64'($urandom_range(0, 100))) * 64'd8;
        return 64'(w) * 64'd8;
    endfunction

    task automatic test_random();
        int          q_due [$];
        logic [63:0] q_val [$];
        logic [63:0] exp_rd;
        logic [63:0] exp_host;
        logic        exp_err;
        int          exp_rdc;
        int          exp_wrc;
        logic [63:0] a;
        int          widx;
        do_reset();
        exp_rd  = 64'h0;
        exp_err = 1'b0;
        exp_rdc = 0;
        exp_wrc = 0;
        for (int c = 0; c < 400; c++) begin
            a              = rand_addr();
            avs_address    = a;
            avs_read       = ($urandom_range(0, 1) == 1);
            avs_write      = ($urandom_range(0, 1) == 1);
            avs_byteenable = 8'($urandom);
            avs_writedata  = {$urandom, $urandom};
            host_we        = ($urandom_range(0, 2) == 0);
            host_addr      = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            host_wdata     = {$urandom, $urandom};
            widx           = int'(a / 64'd8);
            exp_host       = ref_mem[host_addr];
            if (avs_read) begin
                q_due.push_back(c + L);
                q_val.push_back(addr_ok(a) ? ref_mem[widx] : 64'h0);
                exp_rdc++;
            end
            if (avs_write) exp_wrc++;
            if ((avs_read || avs_write) && !addr_ok(a)) exp_err = 1'b1;
            if (host_we && !(avs_write && addr_ok(a) && int'(host_addr) == widx))
                ref_mem[host_addr] = host_wdata;
            if (avs_write && addr_ok(a)) begin
                for (int b = 0; b < 8; b++)
                    if (avs_byteenable[b]) ref_mem[widx][8*b +: 8] = avs_writedata[8*b +: 8];
            end
            tick();
            while (q_due.size() > 0 && q_due[0] == c + 1) begin
                exp_rd = q_val.pop_front();
                void'(q_due.pop_front());
            end
            total++; if (avs_readdata !== exp_rd) begin bad++; $display("FAIL rand_rd cyc=%0d got=%h exp=%h", c, avs_readdata, exp_rd); end
            total++; if (host_rdata !== exp_host) begin bad++; $display("FAIL rand_host cyc=%0d got=%h exp=%h", c, host_rdata, exp_host); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err, exp_err); end
            total++; if (rd_count !== 32'(exp_rdc)) begin bad++; $display("FAIL rand_rd_count cyc=%0d got=%0d exp=%0d", c, rd_count, exp_rdc); end
            total++; if (wr_count !== 32'(exp_wrc)) begin bad++; $display("FAIL rand_wr_count cyc=%0d got=%0d exp=%0d", c, wr_count, exp_wrc); end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_errors();
        do_reset();
        host_write(2, 64'h55);
        avs_read    = 1'b1;
        avs_address = 64'h10;
        tick();
        avs_address = 64'h2000;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
        tick();
        idle();
        total++; if (avs_readdata !== 64'h55) begin bad++; $display("FAIL err_prev_rd got=%h exp=55", avs_readdata); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
        tick();
        total++; if (avs_readdata !== 64'h0) begin bad++; $display("FAIL err_rd_zero got=%h exp=0", avs_readdata); end
        // misaligned and out-of-range writes leave memory untouched
        host_write(1, 64'h77);
        host_write(0, 64'h66);
        avs_write      = 1'b1;
        avs_address    = 64'h0C;
        avs_byteenable = 8'hFF;
        avs_writedata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        avs_address = 64'h2000;
        tick();
        idle();
        host_addr = AW'(1);
        tick();
        total++; if (host_rdata !== 64'h77) begin bad++; $display("FAIL err_misaligned_wr got=%h exp=77", host_rdata); end
        host_addr = AW'(0);
        tick();
        total++; if (host_rdata !== 64'h66) begin bad++; $display("FAIL err_oob_wr got=%h exp=66", host_rdata); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        total++; if (wr_count !== 32'd2) begin bad++; $display("FAIL err_wr_count got=%0d exp=2", wr_count); end
        total++; if (rd_count !== 32'd2) begin bad++; $display("FAIL err_rd_count got=%0d exp=2", rd_count); end
    endtask

    task automatic test_reset_mid();
        host_write(4, 64'h4444_0000_4444);
        avs_read    = 1'b1;
        avs_address = 64'h20;
        tick();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (avs_readdata !== 64'h0) begin bad++; $display("FAIL rstmid_rd i=%0d got=%h exp=0", i, avs_readdata); end
            tick();
        end
        total++; if (rd_count !== 32'h0) begin bad++; $display("FAIL rstmid_rd_count got=%0d exp=0", rd_count); end
        total++; if (wr_count !== 32'h0) begin bad++; $display("FAIL rstmid_wr_count got=%0d exp=0", wr_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", err); end
        host_addr = AW'(4);
        tick();
        total++; if (host_rdata !== 64'h4444_0000_4444) begin bad++; $display("FAIL rstmid_retain got=%h exp=444400004444", host_rdata); end
        host_addr = AW'(9);
        tick();
        total++; if (host_rdata !== ref_mem[9]) begin bad++; $display("FAIL rstmid_retain9 got=%h exp=%h", host_rdata, ref_mem[9]); end
    endtask

    initial begin
        resetn    = 1'b1;
        host_addr = '0;
        idle();
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = 64'h0;
        preload();
        test_reset();
        test_latency();
        test_byteenable();
        test_rw_collision();
        test_host_collision();
        test_random();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
